mult_div_unit: RTL and testbench

Multiply/divide unit for the five-stage pipeline, placed beside the E-stage ALU and fed by the forwarded rs/rt operands of the instruction currently in E. It executes mult, multu, div, divu, mthi and mtlo. It owns the architectural HI/LO registers and exposes a busy flag. The stall logic uses that flag to hold any MDU instruction waiting in D. mfhi/mflo read HI/LO through a combinational read port that feeds the E-stage result path.

---
 rtl/mult_div_unit_pkg.sv | 81 ++++++++
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 83 ++++++++
 tb/tb_mult_div_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared constants, result type and arithmetic helper for the multiply/divide unit.
package mult_div_unit_pkg;

   // Operation encodings carried on the op port
   localparam logic [2:0] MDU_OP_NONE  = 3'd0;
   localparam logic [2:0] MDU_OP_MULT  = 3'd1;
   localparam logic [2:0] MDU_OP_MULTU = 3'd2;
   localparam logic [2:0] MDU_OP_DIV   = 3'd3;
   localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
   localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
   localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

   // Default busy durations
   localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
   localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

   // Width of the busy down-counter
   localparam int unsigned MDU_CNT_W = 4;

   // Result of one mult/div; commit=0 means hi/lo must be left untouched
   typedef struct packed {
      logic        commit;
      logic [31:0] hi;
      logic [31:0] lo;
   } mdu_res_t;

   // True for the operations that occupy the unit for several cycles
   function automatic logic mdu_is_long(input logic [2:0] op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
             (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
   endfunction

   // Full 64-bit result of a mult/div. Signed division works on magnitudes
   // so 0x80000000 / -1 yields 0x80000000 rem 0 without relying on
   // simulator behaviour for the overflowing case.
   function automatic mdu_res_t mdu_compute(input logic [2:0]  op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      mdu_res_t           r;
      logic signed [63:0] sa, sb;
      logic [63:0]        ua, ub, p;
      logic [31:0]        ma, mb, q, rm;
      r  = '0;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      ma = a[31] ? (32'd0 - a) : a;
      mb = b[31] ? (32'd0 - b) : b;
      q  = '0;
      rm = '0;
      case (op)
         MDU_OP_MULT: begin
            p = sa * sb;
            r = '{commit: 1'b1, hi: p[63:32], lo: p[31:0]};
         end
         MDU_OP_MULTU: begin
            p = ua * ub;
            r = '{commit: 1'b1, hi: p[63:32], lo: p[31:0]};
         end
         MDU_OP_DIV: begin
            if (b != 32'd0) begin
               q  = ma / mb;
               rm = ma % mb;
               if (a[31] ^ b[31]) q  = 32'd0 - q;
               if (a[31])         rm = 32'd0 - rm;
               r = '{commit: 1'b1, hi: rm, lo: q};
            end
         end
         MDU_OP_DIVU: begin
            if (b != 32'd0) begin
               r = '{commit: 1'b1, hi: a % b, lo: a / b};
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage <-> multiply/divide unit connection bundle.
interface mult_div_unit_if;
   import mult_div_unit_pkg::*;

   logic        req;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        rd_sel;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rdata;

   // E-stage side: issues operations, watches busy and reads HI/LO
   modport master (
      output req, op, a, b, rd_sel,
      input  start, busy, hi, lo, rdata
   );

   // Unit side
   modport slave (
      input  req, op, a, b, rd_sel,
      output start, busy, hi, lo, rdata
   );
endinterface

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: owns HI/LO, runs mult/div with a fixed busy window,
// executes mthi/mtlo in one cycle and offers a combinational HI/LO read port.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          reset,
   mult_div_unit_if.slave mdu
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]           state;
   logic                 busy;
   logic [MDU_CNT_W-1:0] count;
   logic [31:0]          hi, lo;
   logic [31:0]          ph, pl;
   logic                 pcommit;
   mdu_res_t             res;
   logic                 accept;

   // Result is computed from the operands present on the accepting edge
   assign res    = mdu_compute(mdu.op, mdu.a, mdu.b);
   assign accept = mdu.req && (state == ST_IDLE);

   // State, counter, pending result and architectural HI/LO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         count   <= '0;
         hi      <= '0;
         lo      <= '0;
         ph      <= '0;
         pl      <= '0;
         pcommit <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (mdu_is_long(mdu.op)) begin
                     ph      <= res.hi;
                     pl      <= res.lo;
                     pcommit <= res.commit;
                     count   <= ((mdu.op == MDU_OP_MULT) || (mdu.op == MDU_OP_MULTU))
                                ? MDU_CNT_W'(MULT_CYCLES) : MDU_CNT_W'(DIV_CYCLES);
                     busy    <= 1'b1;
                     state   <= ST_RUN;
                  end else if (mdu.op == MDU_OP_MTHI) begin
                     hi <= mdu.a;
                  end else if (mdu.op == MDU_OP_MTLO) begin
                     lo <= mdu.a;
                  end
               end
            end
            default: begin
               // Requests are ignored here; only the countdown advances
               count <= count - MDU_CNT_W'(1);
               if (count == MDU_CNT_W'(1)) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                  // Divide by zero leaves pcommit clear so HI/LO keep old values
                  if (pcommit) begin
                     hi <= ph;
                     lo <= pl;
                  end
               end
            end
         endcase
      end
   end

   assign mdu.start = mdu.req && mdu_is_long(mdu.op) && !busy;
   assign mdu.busy  = busy;
   assign mdu.hi    = hi;
   assign mdu.lo    = lo;
   assign mdu.rdata = mdu.rd_sel ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with a busy-window scoreboard.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t expq[$];

   mult_div_unit_if mif ();

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (mif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Wait for an idle cycle, then present the operation for exactly one edge
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      while (mif.busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (mif.busy) begin
         n_vec++; n_err++;
         $display("FAIL issue_timeout: busy still %b expected 0", mif.busy);
      end
      mif.req = 1'b1; mif.op = o; mif.a = x; mif.b = y;
      @(posedge clk); #1;
      mif.req = 1'b0; mif.op = MDU_OP_NONE;
   endtask

   task automatic expect_run(input string nm, input logic [31:0] h, input logic [31:0] l, input int c);
      exp_t e;
      e.name = nm; e.hi = h; e.lo = l; e.cyc = c;
      expq.push_back(e);
   endtask

   // Monitor: measures each busy window, checks HI/LO hold during it, and on
   // busy falling compares window length and the now-visible HI/LO
   logic        prev_busy = 1'b0;
   logic [31:0] hold_hi, hold_lo;
   logic        hold_bad;
   int          cyc;
   always @(negedge clk) begin
      exp_t e;
      if (mif.busy) begin
         if (!prev_busy) begin
            hold_hi = mif.hi; hold_lo = mif.lo; hold_bad = 1'b0; cyc = 0;
         end else if (mif.hi !== hold_hi || mif.lo !== hold_lo) begin
            hold_bad = 1'b1;
         end
         cyc++;
      end else if (prev_busy) begin
         if (expq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_completion: busy fell after %0d cycles with no expectation", cyc);
         end else begin
            e = expq.pop_front();
            chk({e.name, "_busy_cycles"}, 32'(cyc), 32'(e.cyc));
            chk({e.name, "_hold"}, {31'b0, hold_bad}, 32'd0);
            chk({e.name, "_hi"}, mif.hi, e.hi);
            chk({e.name, "_lo"}, mif.lo, e.lo);
         end
      end
      prev_busy = mif.busy;
   end

   initial begin
      int n;
      mif.req = 1'b0; mif.op = MDU_OP_NONE; mif.a = '0; mif.b = '0; mif.rd_sel = 1'b0;
      reset = 1'b1;
      #1;
      chk("reset_busy", {31'b0, mif.busy}, 32'd0);
      chk("reset_hi", mif.hi, 32'd0);
      chk("reset_lo", mif.lo, 32'd0);
      chk("reset_rdata", mif.rdata, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // start is combinational; withdrawn before the edge so nothing is accepted
      mif.req = 1'b1; mif.op = MDU_OP_MULTU; #1;
      chk("start_multu", {31'b0, mif.start}, 32'd1);
      mif.op = MDU_OP_MTHI; #1;
      chk("start_mthi", {31'b0, mif.start}, 32'd0);
      mif.req = 1'b0; mif.op = MDU_OP_MULT; #1;
      chk("start_noreq", {31'b0, mif.start}, 32'd0);
      mif.op = MDU_OP_NONE;
      @(posedge clk); #1;

      expect_run("mult_m1x2",  32'hFFFFFFFF, 32'hFFFFFFFE, 5);
      issue(MDU_OP_MULT, 32'hFFFFFFFF, 32'h2);
      expect_run("multu_max2", 32'h00000001, 32'hFFFFFFFE, 5);
      issue(MDU_OP_MULTU, 32'hFFFFFFFF, 32'h2);
      expect_run("mult_m3xm4", 32'h00000000, 32'h0000000C, 5);
      issue(MDU_OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFC);
      expect_run("div_m7_2",   32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(MDU_OP_DIV, 32'hFFFFFFF9, 32'h2);
      expect_run("div_7_m2",   32'h00000001, 32'hFFFFFFFD, 10);
      issue(MDU_OP_DIV, 32'h7, 32'hFFFFFFFE);
      expect_run("div_ovf",    32'h00000000, 32'h80000000, 10);
      issue(MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      expect_run("divu_max16", 32'h0000000F, 32'h0FFFFFFF, 10);
      issue(MDU_OP_DIVU, 32'hFFFFFFFF, 32'h10);

      // mthi/mtlo take effect on the next edge and never raise busy
      issue(MDU_OP_MTHI, 32'h11, 32'h0);
      mif.rd_sel = 1'b1; #1;
      chk("mthi_rdata", mif.rdata, 32'h11);
      chk("mthi_busy", {31'b0, mif.busy}, 32'd0);
      issue(MDU_OP_MTLO, 32'h22, 32'h0);
      mif.rd_sel = 1'b0; #1;
      chk("mtlo_rdata", mif.rdata, 32'h22);
      chk("mtlo_hi_kept", mif.hi, 32'h11);

      expect_run("divu_by0", 32'h11, 32'h22, 10);
      issue(MDU_OP_DIVU, 32'h7, 32'h0);

      // mtlo arriving in the second busy cycle must be ignored
      expect_run("mult_ign_mtlo", 32'h0, 32'hF, 5);
      issue(MDU_OP_MULT, 32'h3, 32'h5);
      @(posedge clk); #1;
      mif.req = 1'b1; mif.op = MDU_OP_MTLO; mif.a = 32'h55; #1;
      chk("busy_start", {31'b0, mif.start}, 32'd0);
      @(posedge clk); #1;
      mif.req = 1'b0; mif.op = MDU_OP_NONE;

      // reset in the 4th busy cycle of a divide discards the pending result
      expect_run("div_reset", 32'h0, 32'h0, 3);
      issue(MDU_OP_DIV, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1; #1;
      chk("rst_mid_busy", {31'b0, mif.busy}, 32'd0);
      chk("rst_mid_hi", mif.hi, 32'd0);
      chk("rst_mid_lo", mif.lo, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst_busy", {31'b0, mif.busy}, 32'd0);
      chk("post_rst_hi", mif.hi, 32'd0);
      chk("post_rst_lo", mif.lo, 32'd0);

      n = 0;
      while (expq.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      while (expq.size() != 0) begin
         exp_t e;
         e = expq.pop_front();
         n_vec++; n_err++;
         $display("FAIL %s: no completion seen, expected busy for %0d cycles", e.name, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
